uart_pwm_cmd_ctrl: RTL and testbench
====================================

Name: uart_pwm_cmd_ctrl

Overview:
Command sequencer between uart_rx and the 256-channel PWM generator. It parses framed byte commands received over UART and validates each frame's checksum. For each valid frame it issues a single-cycle write of an 8-bit duty value into the PWM duty register file, then queues an ACK or NAK byte for the UART transmitter. It also enforces an inter-byte timeout and keeps a saturating error count.

Parameters:
CLKS_PER_BIT, 217, UART bit period in i_Clock cycles (25 MHz / 115200); used only to derive the default timeout.
TIMEOUT_CLKS, 4340, idle cycles allowed between bytes inside a frame (20 bit periods).
SYNC_BYTE, 8'hA5, frame start marker.
ACK_BYTE, 8'h06, response for a good frame.
NAK_BYTE, 8'h15, response for a checksum failure.

Ports:
i_Clock  in  1  system clock.
i_Reset  in  1  asynchronous active-high reset.
i_RX_DV  in  1  single-cycle byte-valid pulse from uart_rx.
i_RX_Byte  in  8  received byte; valid when i_RX_DV=1.
i_TX_Active  in  1  UART transmitter busy; high means it cannot accept a byte.
o_TX_DV  out  1  single-cycle request to transmit o_TX_Byte.
o_TX_Byte  out  8  response byte; stable while a response is pending.
o_Wr_En  out  1  single-cycle duty register write strobe.
o_Wr_Addr  out  8  PWM channel index, 0..255.
o_Wr_Data  out  8  duty value, 0..255.
o_Err_Count  out  8  saturating count of checksum and timeout errors.
o_Busy  out  1  high whenever the FSM is not in S_IDLE.

Behaviour:
- Reset (asynchronous, any cycle including mid-frame or mid-response):
  - FSM goes to S_IDLE; timer cleared; pending response cleared.
  - All outputs go to 0.
- Frame format: SYNC_BYTE, CHAN, DUTY, CSUM, where CSUM = CHAN ^ DUTY.
- FSM states and transitions (evaluated only on i_RX_DV):
  - S_IDLE -> S_CHAN when byte == SYNC_BYTE. Any other byte is ignored and is not counted as an error.
  - S_CHAN: latch CHAN, go to S_DUTY. A SYNC_BYTE value here is treated as data, not as a restart.
  - S_DUTY: latch DUTY, go to S_CSUM.
  - S_CSUM: compare byte with CHAN ^ DUTY, then go to S_IDLE.
    - Match: on the next cycle o_Wr_En=1 for exactly one cycle, with o_Wr_Addr=CHAN and o_Wr_Data=DUTY. Queue ACK_BYTE.
    - Mismatch: no write. Queue NAK_BYTE. o_Err_Count increments.
- Write timing: write latency is 1 cycle after the i_RX_DV of the CSUM byte. o_Wr_Addr and o_Wr_Data hold their last value between writes.
- Timeout:
  - The timer counts cycles with no i_RX_DV while in S_CHAN, S_DUTY or S_CSUM; it restarts on every i_RX_DV.
  - On reaching TIMEOUT_CLKS-1: go to S_IDLE, discard the frame, send no response, increment o_Err_Count.
  - If i_RX_DV arrives in the same cycle the timer expires, the byte wins and there is no timeout.
- Response path (one-entry pending register):
  - When pending and i_TX_Active=0, o_TX_DV=1 for one cycle and pending clears.
  - While i_TX_Active=1, the byte is held and o_TX_DV stays 0.
  - A new response arriving while one is still pending overwrites it (latest wins).
- o_Err_Count: saturates at 255 and never wraps. A checksum error and a timeout cannot occur in the same cycle.
- o_Busy: combinational, (state != S_IDLE).

Decomposition:
- Shared package holds:
  - 2-bit state encoding: S_IDLE, S_CHAN, S_DUTY, S_CSUM.
  - Default SYNC, ACK and NAK byte constants.
  - The TIMEOUT_CLKS derivation from CLKS_PER_BIT.
- One natural sub-module, uart_frame_timer: a loadable down-counter with restart and enable inputs and a one-cycle expire pulse.
- FSM, checksum compare, response register and error counter stay in the top module.

Test Plan:
1. Frame A5,10,80,90 with i_TX_Active=0 -> one o_Wr_En pulse with Addr=0x10, Data=0x80, 1 cycle after the last DV; then o_TX_DV pulse with byte 0x06; o_Err_Count=0.
2. Frame A5,10,80,00 -> no o_Wr_En; o_TX_Byte=0x15 with one o_TX_DV pulse; o_Err_Count=1.
3. Bytes 00,37 then A5,10, followed by TIMEOUT_CLKS idle cycles -> o_Busy falls, o_Err_Count=1, no TX. A following frame A5,FF,FF,00 writes Addr=0xFF, Data=0xFF and ACKs.
4. Hold i_TX_Active=1 through completion of frame A5,01,02,03 -> o_TX_DV stays 0. Drop i_TX_Active -> exactly one o_TX_DV pulse, byte 0x06.
5. Assert i_Reset after A5,10 -> outputs 0 and o_Busy=0 immediately. After release, bytes 80,90 alone produce no write.
6. Send 300 bad-checksum frames -> o_Err_Count stops at 255.

Source files
------------

// File: rtl/uart_pwm_cmd_ctrl_pkg.sv
// Shared types and constants for the UART-to-PWM command sequencer.
// The inter-byte timeout defaults to 20 UART bit periods.
package uart_pwm_cmd_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CHAN = 2'd1,
        S_DUTY = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
    localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

    localparam int unsigned TIMEOUT_BIT_PERIODS = 20;

    function automatic int unsigned timeout_clks(input int unsigned clks_per_bit);
        return clks_per_bit * TIMEOUT_BIT_PERIODS;
    endfunction

endpackage

// File: rtl/uart_pwm_cmd_ctrl_timer.sv
// Loadable down-counter: restart reloads, enable counts down, and expire
// pulses when an enabled count sits at zero with no restart that cycle.
module uart_frame_timer #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // restart has priority so a byte arriving on the expiry cycle wins
    assign expire = enable && !restart && (count == '0);

endmodule

// File: rtl/uart_pwm_cmd_ctrl.sv
// Parses SYNC/CHAN/DUTY/CSUM frames from uart_rx, writes the PWM duty file on
// a good checksum, queues ACK/NAK for uart_tx and counts errors.
module uart_pwm_cmd_ctrl
    import uart_pwm_cmd_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned TIMEOUT_CLKS = timeout_clks(CLKS_PER_BIT),
    parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter logic [7:0]  ACK_BYTE     = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE     = DEF_NAK_BYTE
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_TX_Active,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic [7:0] o_Err_Count,
    output logic       o_Busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

    state_t     state, next_state;
    logic [7:0] chan, duty;
    logic       pending;
    logic       csum_ok, csum_bad, timeout;

    uart_frame_timer #(.WIDTH(TW)) u_timer (
        .clk        (i_Clock),
        .rst        (i_Reset),
        .restart    (i_RX_DV),
        .enable     (state != S_IDLE),
        .load_value (TW'(TIMEOUT_CLKS - 1)),
        .expire     (timeout)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        csum_ok    = 1'b0;
        csum_bad   = 1'b0;
        case (state)
            S_IDLE: if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) next_state = S_CHAN;
            S_CHAN: if (i_RX_DV) next_state = S_DUTY;
            S_DUTY: if (i_RX_DV) next_state = S_CSUM;
            S_CSUM: begin
                if (i_RX_DV) begin
                    next_state = S_IDLE;
                    csum_ok    = (i_RX_Byte == (chan ^ duty));
                    csum_bad   = !csum_ok;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (timeout) next_state = S_IDLE;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            chan        <= '0;
            duty        <= '0;
            o_Wr_En     <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= '0;
            pending     <= 1'b0;
            o_TX_Byte   <= '0;
            o_Err_Count <= '0;
        end else begin
            if (i_RX_DV && (state == S_CHAN)) chan <= i_RX_Byte;
            if (i_RX_DV && (state == S_DUTY)) duty <= i_RX_Byte;

            o_Wr_En <= csum_ok;
            if (csum_ok) begin
                o_Wr_Addr <= chan;
                o_Wr_Data <= duty;
            end

            // a fresh response overwrites one still waiting for the transmitter
            if (csum_ok || csum_bad) begin
                pending   <= 1'b1;
                o_TX_Byte <= csum_ok ? ACK_BYTE : NAK_BYTE;
            end else if (pending && !i_TX_Active) begin
                pending <= 1'b0;
            end

            if ((csum_bad || timeout) && (o_Err_Count != 8'hFF))
                o_Err_Count <= o_Err_Count + 8'd1;
        end
    end

    assign o_TX_DV = pending && !i_TX_Active;
    assign o_Busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and random
// frames compared each cycle against a frame-level reference model.
module tb_uart_pwm_cmd_ctrl;

    localparam int unsigned T = 40;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_active;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data, err_count;
    logic       busy;

    always #5 clk = ~clk;

    uart_pwm_cmd_ctrl #(
        .CLKS_PER_BIT (217),
        .TIMEOUT_CLKS (T)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .i_TX_Active (tx_active),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .o_Wr_En     (wr_en),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .o_Err_Count (err_count),
        .o_Busy      (busy)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned tx_seen = 0;
    int unsigned wr_seen = 0;

    // Reference model: bytes of the frame in progress, idle gap, and the
    // externally visible results of completed frames.
    logic [7:0] frame[$];
    int unsigned gap;
    logic       m_wr_en, m_pend;
    logic [7:0] m_addr, m_data, m_txb, m_err;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        frame.delete();
        gap = 0;
        m_wr_en = 0; m_pend = 0;
        m_addr = 0; m_data = 0; m_txb = 0; m_err = 0;
    endtask

    task automatic bump_err();
        if (m_err < 8'd255) m_err = m_err + 8'd1;
    endtask

    task automatic model_step();
        logic       resp;
        logic [7:0] rb;
        resp = 0; rb = 0;
        m_wr_en = 0;
        if (frame.size() == 0) begin
            if (rx_dv && rx_byte == SYNC) begin
                frame.push_back(rx_byte);
                gap = 0;
            end
        end else if (rx_dv) begin
            frame.push_back(rx_byte);
            gap = 0;
            if (frame.size() == 4) begin
                resp = 1;
                if (frame[3] == (frame[1] ^ frame[2])) begin
                    m_wr_en = 1; m_addr = frame[1]; m_data = frame[2]; rb = ACK;
                end else begin
                    rb = NAK; bump_err();
                end
                frame.delete();
            end
        end else begin
            gap++;
            if (gap == T) begin
                frame.delete();
                bump_err();
            end
        end
        if (resp) begin
            m_pend = 1; m_txb = rb;
        end else if (m_pend && !tx_active) begin
            m_pend = 0;
        end
    endtask

    task automatic check_model();
        if (tx_dv === 1'b1) tx_seen++;
        if (wr_en === 1'b1) wr_seen++;
        chk("wr_en",   wr_en,     m_wr_en);
        chk("wr_addr", wr_addr,   m_addr);
        chk("wr_data", wr_data,   m_data);
        chk("tx_dv",   tx_dv,     m_pend && !tx_active);
        chk("tx_byte", tx_byte,   m_txb);
        chk("err",     err_count, m_err);
        chk("busy",    busy,      frame.size() != 0);
    endtask

    // Drive one cycle: inputs after the edge, compare at negedge, model at posedge.
    task automatic cycle(input logic dv, input logic [7:0] b, input logic txa);
        rx_dv = dv; rx_byte = b; tx_active = txa;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
        rx_dv = 0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] s, input logic txa);
        cycle(1, SYNC, txa);
        cycle(1, c, txa);
        cycle(1, d, txa);
        cycle(1, s, txa);
    endtask

    task automatic idle(input int unsigned n, input logic txa);
        for (int unsigned i = 0; i < n; i++) cycle(0, 8'h00, txa);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    typedef struct {
        logic       dv;
        logic [7:0] b;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       txdv;
        logic [7:0] txb;
        logic [7:0] err;
        logic       bsy;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int unsigned base_tx, base_wr;
        logic [7:0] c, d, s;

        // expected outputs sampled in the same cycle the inputs are applied
        tbl[0]  = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'd0, 0};
        tbl[1]  = '{1, 8'hA5, 0, 8'h00, 8'h00, 0, 8'h00, 8'd0, 0};
        tbl[2]  = '{1, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 8'd0, 1};
        tbl[3]  = '{1, 8'h80, 0, 8'h00, 8'h00, 0, 8'h00, 8'd0, 1};
        tbl[4]  = '{1, 8'h90, 0, 8'h00, 8'h00, 0, 8'h00, 8'd0, 1};
        tbl[5]  = '{0, 8'h00, 1, 8'h10, 8'h80, 1, 8'h06, 8'd0, 0};
        tbl[6]  = '{0, 8'h00, 0, 8'h10, 8'h80, 0, 8'h06, 8'd0, 0};
        tbl[7]  = '{1, 8'hA5, 0, 8'h10, 8'h80, 0, 8'h06, 8'd0, 0};
        tbl[8]  = '{1, 8'h10, 0, 8'h10, 8'h80, 0, 8'h06, 8'd0, 1};
        tbl[9]  = '{1, 8'h80, 0, 8'h10, 8'h80, 0, 8'h06, 8'd0, 1};
        tbl[10] = '{1, 8'h00, 0, 8'h10, 8'h80, 0, 8'h06, 8'd0, 1};
        tbl[11] = '{0, 8'h00, 0, 8'h10, 8'h80, 1, 8'h15, 8'd1, 0};
        tbl[12] = '{0, 8'h00, 0, 8'h10, 8'h80, 0, 8'h15, 8'd1, 0};

        rx_dv = 0; rx_byte = 0; tx_active = 0;
        rst = 1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        // good frame then bad-checksum frame
        for (int i = 0; i < 13; i++) begin
            rx_dv = tbl[i].dv; rx_byte = tbl[i].b; tx_active = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_wr_en", i),   wr_en,     tbl[i].wr);
            chk($sformatf("tbl%0d_wr_addr", i), wr_addr,   tbl[i].addr);
            chk($sformatf("tbl%0d_wr_data", i), wr_data,   tbl[i].data);
            chk($sformatf("tbl%0d_tx_dv", i),   tx_dv,     tbl[i].txdv);
            chk($sformatf("tbl%0d_tx_byte", i), tx_byte,   tbl[i].txb);
            chk($sformatf("tbl%0d_err", i),     err_count, tbl[i].err);
            chk($sformatf("tbl%0d_busy", i),    busy,      tbl[i].bsy);
            @(posedge clk);
            model_step();
            #1;
        end

        // junk bytes, partial frame, timeout boundary
        do_reset();
        base_tx = tx_seen;
        cycle(1, 8'h00, 0);
        cycle(1, 8'h37, 0);
        cycle(1, SYNC, 0);
        cycle(1, 8'h10, 0);
        idle(T - 1, 0);
        chk("busy_before_timeout", busy, 1);
        chk("err_before_timeout", err_count, 0);
        idle(1, 0);
        chk("busy_after_timeout", busy, 0);
        chk("err_after_timeout", err_count, 1);
        idle(3, 0);
        chk("no_tx_on_timeout", tx_seen - base_tx, 0);
        send_frame(8'hFF, 8'hFF, 8'h00, 0);
        chk("wr_en_ff", wr_en, 1);
        chk("wr_addr_ff", wr_addr, 8'hFF);
        chk("wr_data_ff", wr_data, 8'hFF);
        idle(2, 0);
        chk("ack_ff", tx_byte, ACK);

        // byte on the expiry cycle keeps the frame alive
        cycle(1, SYNC, 0);
        idle(T - 1, 0);
        cycle(1, 8'h20, 0);
        chk("busy_byte_wins", busy, 1);
        cycle(1, 8'h30, 0);
        cycle(1, 8'h10, 0);
        chk("wr_addr_byte_wins", wr_addr, 8'h20);
        chk("err_byte_wins", err_count, 1);
        idle(2, 0);

        // response held while the transmitter is busy
        do_reset();
        base_tx = tx_seen;
        send_frame(8'h01, 8'h02, 8'h03, 1);
        idle(6, 1);
        chk("tx_held", tx_seen - base_tx, 0);
        idle(5, 0);
        chk("tx_one_pulse", tx_seen - base_tx, 1);
        chk("tx_ack_held", tx_byte, ACK);

        // latest response overwrites a pending one
        send_frame(8'h05, 8'h06, 8'h00, 1);
        send_frame(8'h07, 8'h08, 8'h0F, 1);
        idle(2, 1);
        chk("overwrite_byte", tx_byte, ACK);
        idle(3, 0);

        // asynchronous reset mid-frame
        send_frame(8'h12, 8'h34, 8'h26, 0);
        cycle(1, SYNC, 0);
        cycle(1, 8'h10, 0);
        #2;
        rst = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_err", err_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        base_wr = wr_seen;
        cycle(1, 8'h80, 0);
        cycle(1, 8'h90, 0);
        idle(3, 0);
        chk("no_wr_after_reset", wr_seen - base_wr, 0);

        // error counter saturation
        for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h00, 8'h01, 0);
        idle(2, 0);
        chk("err_saturated", err_count, 255);

        // randomized frames against the model
        do_reset();
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 3) == 0) cycle(1, 8'($urandom), $urandom_range(0, 2) == 0);
            c = 8'($urandom);
            d = 8'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ d);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 15) == 0)
                    idle($urandom_range(T - 2, T + 1), $urandom_range(0, 2) == 0);
                else
                    idle($urandom_range(0, 4), $urandom_range(0, 2) == 0);
                case (k)
                    0: cycle(1, SYNC, $urandom_range(0, 2) == 0);
                    1: cycle(1, c, $urandom_range(0, 2) == 0);
                    2: cycle(1, d, $urandom_range(0, 2) == 0);
                    default: cycle(1, s, $urandom_range(0, 2) == 0);
                endcase
            end
        end
        idle(T + 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
